// File: rtl/gf2m_multi_square.sv
// Repeated squaring engine over GF(2^M) with trinomial x^M + x^K + 1: result = a^(2^n),
// performing up to P squarings per clock with a start/busy/done handshake.
module gf2m_multi_square #(
    parameter int M   = 233,
    parameter int K   = 74,
    parameter int N_W = 8,
    parameter int P   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [M-1:0]   a,
    output logic           busy,
    output logic           done,
    output logic [M-1:0]   result
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   acc_q, acc_d;
    logic [M-1:0]   result_q, result_d;
    logic [N_W-1:0] rem_q, rem_d;
    logic           done_q, done_d;

    logic [M-1:0]   sq_stage [0:P];
    logic [N_W-1:0] step;
    logic [M-1:0]   sq_sel;

    // Spread bit i to 2i, then fold x^M = x^K + 1 from the top down so that bits
    // produced by an earlier fold are themselves folded when still >= M.
    function automatic logic [M-1:0] gf_sq(input logic [M-1:0] x);
        logic [2*M-2:0] w;
        w = '0;
        for (int i = 0; i < M; i++) begin
            w[2*i] = x[i];
        end
        for (int i = 2*M-2; i >= M; i--) begin
            w[i-M+K] = w[i-M+K] ^ w[i];
            w[i-M]   = w[i-M] ^ w[i];
        end
        return w[M-1:0];
    endfunction

    assign sq_stage[0] = acc_q;

    generate
        for (genvar gi = 1; gi <= P; gi++) begin : g_stage
            assign sq_stage[gi] = gf_sq(sq_stage[gi-1]);
        end
    endgenerate

    // The last step of a job may need fewer than P squarings.
    always_comb begin
        step   = (rem_q < N_W'(P)) ? rem_q : N_W'(P);
        sq_sel = sq_stage[0];
        for (int j = 1; j <= P; j++) begin
            if (step == N_W'(j)) begin
                sq_sel = sq_stage[j];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n == '0) begin
                        result_d = a;
                        done_d   = 1'b1;
                    end else begin
                        acc_d   = a;
                        rem_d   = n;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = sq_sel;
                rem_d = rem_q - step;
                if (rem_q == step) begin
                    result_d = sq_sel;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_gf2m_multi_square.sv
// Bench for gf2m_multi_square: four instances (P=1..4) checked every cycle against a
// job-level model built on a bit-serial GF(2^233) multiplier, plus directed literal checks.
module tb_gf2m_multi_square;

    localparam int M   = 233;
    localparam int K   = 74;
    localparam int N_W = 8;
    localparam int ND  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic           st     [ND];
    logic [N_W-1:0] nn     [ND];
    logic [M-1:0]   aa     [ND];
    logic           busy_o [ND];
    logic           done_o [ND];
    logic [M-1:0]   res_o  [ND];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            gf2m_multi_square #(.M(M), .K(K), .N_W(N_W), .P(gi + 1)) u_dut (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (st[gi]),
                .n      (nn[gi]),
                .a      (aa[gi]),
                .busy   (busy_o[gi]),
                .done   (done_o[gi]),
                .result (res_o[gi])
            );
        end
    endgenerate

    // ---------------- reference arithmetic ----------------
    function automatic logic [M-1:0] bitv(input int i);
        logic [M-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Shift-and-add multiply, MSB first, reducing by x^M = x^K + 1 after each shift.
    function automatic logic [M-1:0] gmul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] r;
        logic [M-1:0] poly_low;
        logic         top;
        poly_low = bitv(K) | bitv(0);
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            top = r[M-1];
            r   = r << 1;
            if (top) r = r ^ poly_low;
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] frob(input logic [M-1:0] x, input int cnt);
        logic [M-1:0] r;
        r = x;
        for (int i = 0; i < cnt; i++) r = gmul(r, r);
        return r;
    endfunction

    function automatic logic [M-1:0] rand_a();
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = (r << 32) ^ M'($urandom());
        return r;
    endfunction

    // ---------------- job-level model ----------------
    bit           e_busy [ND];
    bit           e_done [ND];
    logic [M-1:0] e_res  [ND];
    logic [M-1:0] m_pend [ND];
    int           m_cnt  [ND];

    initial begin
        for (int d = 0; d < ND; d++) begin
            e_busy[d] = 1'b0; e_done[d] = 1'b0; e_res[d] = '0; m_pend[d] = '0; m_cnt[d] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < ND; d++) begin
                if (!rst_n) begin
                    e_busy[d] = 1'b0; e_done[d] = 1'b0; e_res[d] = '0; m_cnt[d] = 0;
                end else begin
                    e_done[d] = 1'b0;
                    if (m_cnt[d] > 0) begin
                        m_cnt[d]--;
                        if (m_cnt[d] == 0) begin
                            e_done[d] = 1'b1;
                            e_busy[d] = 1'b0;
                            e_res[d]  = m_pend[d];
                        end
                    end else if (st[d] === 1'b1) begin
                        if (nn[d] == 0) begin
                            e_done[d] = 1'b1;
                            e_res[d]  = aa[d];
                        end else begin
                            m_cnt[d]  = (int'(nn[d]) + d) / (d + 1);
                            m_pend[d] = frob(aa[d], int'(nn[d]));
                            e_busy[d] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < ND; d++) begin
                    vectors++;
                    if (busy_o[d] !== e_busy[d] || done_o[d] !== e_done[d] || res_o[d] !== e_res[d]) begin
                        miscompares++;
                        $display("FAIL model_cmp P=%0d t=%0t got busy=%0b done=%0b result=%h required busy=%0b done=%0b result=%h",
                                 d + 1, $time, busy_o[d], done_o[d], res_o[d], e_busy[d], e_done[d], e_res[d]);
                    end
                end
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issue one job at a negedge; returns at the negedge of the done cycle.
    task automatic job(input int d, input string name, input int n, input logic [M-1:0] a,
                       output logic [M-1:0] res);
        int lat, bc, c;
        c   = (n + d) / (d + 1);
        st[d] = 1'b1; nn[d] = N_W'(n); aa[d] = a;
        lat = 0; bc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                st[d] = 1'b0; nn[d] = N_W'($urandom()); aa[d] = rand_a();
            end
            if (busy_o[d] === 1'b1) bc++;
        end while (done_o[d] !== 1'b1 && lat < 400);
        res = res_o[d];
        check_i({name, "_latency"}, lat, c + 1);
        check_i({name, "_busy_cycles"}, bc, c);
    endtask

    initial begin
        logic [M-1:0] r, ra, rb, exp_bits;
        int t;
        for (int d = 0; d < ND; d++) begin
            st[d] = 1'b0; nn[d] = '0; aa[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int d = 0; d < ND; d++) begin
            check_i("reset_busy", int'(busy_o[d]), 0);
            check_i("reset_done", int'(done_o[d]), 0);
            check("reset_result", res_o[d], '0);
        end

        // pin the reference model with hand-derived values
        exp_bits = bitv(231) | bitv(146) | bitv(72);
        check("model_sq_x232", gmul(bitv(232), bitv(232)), exp_bits);
        check("model_x_pow32", frob(bitv(1), 5), bitv(32));

        // basis, P=1
        job(0, "basis_x", 1, bitv(1), r);
        check("basis_x_result", r, bitv(2));
        job(0, "basis_x232", 1, bitv(232), r);
        check("basis_x232_result", r, exp_bits);

        // Frobenius: a^(2^233) = a
        ra = rand_a();
        job(0, "frob_p1", 233, ra, r);
        check("frob_p1_result", r, ra);
        ra = rand_a();
        job(3, "frob_p4", 233, ra, r);
        check("frob_p4_result", r, ra);

        // partial last step and n=0, P=2
        job(1, "partial_p2", 5, bitv(1), r);
        check("partial_p2_result", r, bitv(32));
        job(1, "zero_n", 0, M'(5), r);
        check("zero_n_result", r, M'(5));

        // start during RUN is ignored
        ra = rand_a();
        rb = rand_a();
        st[0] = 1'b1; nn[0] = 8'd10; aa[0] = ra;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        st[0] = 1'b1; nn[0] = 8'd3; aa[0] = rb;
        @(negedge clk);
        st[0] = 1'b0;
        t = 5;
        while (done_o[0] !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_i("ignore_start_latency", t, 11);
        check("ignore_start_result", res_o[0], frob(ra, 10));
        // back-to-back start in the done cycle
        job(0, "b2b_first", 7, bitv(3), r);
        check("b2b_first_result", r, frob(bitv(3), 7));
        job(0, "b2b_second", 2, bitv(5), r);
        check("b2b_second_result", r, bitv(20));

        // identity
        job(0, "ident_1", 1, M'(1), r);
        check("ident_1_result", r, M'(1));
        job(0, "ident_17", 17, M'(1), r);
        check("ident_17_result", r, M'(1));
        job(0, "ident_255", 255, M'(1), r);
        check("ident_255_result", r, M'(1));

        // asynchronous reset mid-run
        job(0, "pre_reset", 1, bitv(100), r);
        st[0] = 1'b1; nn[0] = 8'd100; aa[0] = rand_a();
        @(negedge clk);
        st[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_i("midrun_busy_before", int'(busy_o[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_i("async_reset_busy", int'(busy_o[0]), 0);
        check_i("async_reset_done", int'(done_o[0]), 0);
        check("async_reset_result", res_o[0], '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_i("after_reset_idle", int'(busy_o[0]), 0);
        job(0, "post_reset", 1, M'(2), r);
        check("post_reset_result", r, M'(4));

        // random jobs on P=3, checked by the model every cycle
        for (int i = 0; i < 1000; i++) begin
            job(2, "rand_p3", int'($urandom_range(0, 255)), rand_a(), r);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gf2m_multi_square.md
# gf2m_multi_square

Sequential repeated-squaring engine over GF(2^M) with a trinomial reduction polynomial. It computes a^(2^n) for a run-time count n, performing P squarings per clock. It is the parametrised, handshaked successor of the fixed-field combinational quad block and serves the Itoh-Tsujii inversion and point-arithmetic datapaths of the ECC core (default field B-233, x^233 + x^74 + 1).

## Interface

Parameters:
- M, 233, field degree; operand width.
- K, 74, middle term of the reduction trinomial x^M + x^K + 1; legal range 1 <= K <= (M-1)/2.
- N_W, 8, width of the squaring-count input n.
- P, 1, squarings per clock; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- n  in  N_W  number of squarings; sampled with start.
- a  in  M  operand; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle completion pulse.
- result  out  M  a^(2^n) mod f(x); held from done until the next completion.

## Operation

- States: IDLE, RUN. Internal registers: acc[M-1:0], rem[N_W-1:0].
- Reset (async assert, any state, mid-run included): state=IDLE, busy=0, done=0, result=0, acc=0, rem=0. The in-flight job is discarded.
- IDLE, start=1, n=0: result<=a, done<=1, remain in IDLE.
- IDLE, start=1, n>0: acc<=a, rem<=n, go to RUN, busy<=1.
- RUN, each edge: s = min(P, rem); acc <= sq^s(acc); rem <= rem - s.
  - If rem - s == 0 at that edge: result <= sq^s(acc), done <= 1, busy <= 0, go to IDLE.
- start is ignored while in RUN. a and n are not required to stay stable after the start edge.
- done is 0 on every edge that does not complete a job, so it is a 1-cycle pulse.
- A new start is accepted in the cycle in which done=1, because state is already IDLE.
- Squaring: sq(x) spreads bit i to bit 2i (degree <= 2M-2), then reduces with x^M = x^K + 1.
  - The fold is applied repeatedly until the degree is < M. Two folds suffice under the K constraint.
  - The logic is purely combinational XOR and chained P times for a single cycle.
- Arithmetic is carry-free, so there is no overflow. rem is unsigned and never underflows, because s <= rem.

## Timing

- Start edge = the edge at which start=1 is sampled in IDLE.
- n=0: done=1 and result valid in the cycle after the start edge. Latency 1.
- n>0: done=1 in the cycle after edge number C = ceil(n/P) counted after the start edge. Latency C+1 cycles from the start edge.
- busy is high for exactly C cycles.
- Peak throughput: one job every C+1 cycles, with back-to-back start allowed on the done cycle.
- result changes only on a completion edge. It is stable at all other times.
- Critical path: P chained squarer/reducer stages. P=1 is the timing-closure baseline.

## Test plan

- Reset mid-run: assert rst_n=0 during RUN with P=1, n=100 -> busy=0, done=0, result=0 immediately (asynchronous). After release the block is idle, and a fresh start with n=1, a=2 yields result=4.
- Basis check, M=233, K=74, P=1: a=bit1, n=1 -> result=bit2, done 2 cycles after the start edge. a=bit232, n=1 -> result has exactly bits {231,146,72} set.
- Frobenius, P=1 and P=4: a random, n=233 -> result=a. busy high for 233 cycles (P=1) and 59 cycles (P=4).
- Partial last step, P=2, n=5, a=bit1 -> result=bit32, busy high 3 cycles, done 4 cycles after the start edge. n=0, a=0x5 -> result=0x5, done the next cycle with busy never set.
- Handshake: pulse start during RUN with different a/n -> ignored, result matches the first job. Assert start in the done cycle -> second job accepted, and its done arrives C+1 cycles later.
- Identity and reference model: a=1 for n in {1, 17, 255} -> result=1. 1000 random (a, n) pairs with P=3 match a bit-serial software model, with exactly one done pulse per accepted start.
